// File: rtl/half_word_loader_pkg.sv
// Shared encodings for the half-word loader: FSM states, request modes and
// the select codes understood by the external half-word mux.
`timescale 1ns/1ps
package half_word_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [1:0] MODE_LO   = 2'b00;  // zero-extend low half
  localparam logic [1:0] MODE_HI   = 2'b01;  // low half placed in upper half
  localparam logic [1:0] MODE_FULL = 2'b10;  // full word in two passes
  localparam logic [1:0] MODE_ILL  = 2'b11;  // illegal, flagged as error

  localparam logic [1:0] SEL_LO   = 2'b00;
  localparam logic [1:0] SEL_HI   = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

endpackage

// File: rtl/half_word_loader.sv
// Half-word loader: sequences an external half-word mux to build a word
// one half at a time, OR-ing each mux result into an accumulator.
`timescale 1ns/1ps
module half_word_loader
  import half_word_loader_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_mode,
  input  logic [W-1:0] req_data,
  output logic [1:0]   mux_sel,
  output logic [W-1:0] mux_dato,
  input  logic [W-1:0] mux_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic         busy
);

  localparam int H = W / 2;

  state_t       state_reg;
  state_t       state_next;
  logic [W-1:0] word_reg;
  logic [1:0]   mode_reg;
  logic [W-1:0] acc_reg;
  logic         err_reg;
  logic         accept;

  // Requests are only taken in IDLE and never while reset is held.
  assign req_ready = (state_reg == ST_IDLE) && !RESET;
  assign accept    = req_valid && req_ready;

  assign busy      = (state_reg != ST_IDLE);
  assign res_valid = (state_reg == ST_DONE);
  assign res_data  = res_valid ? acc_reg : '0;
  assign res_err   = res_valid && err_reg;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and mux drive for the current phase.
  always_comb begin
    state_next = state_reg;
    mux_sel    = SEL_ZERO;
    mux_dato   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (req_mode)
            MODE_LO, MODE_FULL: state_next = ST_LOW;
            MODE_HI:            state_next = ST_HIGH;
            default:            state_next = ST_DONE;
          endcase
        end
      end
      ST_LOW: begin
        mux_sel    = SEL_LO;
        mux_dato   = word_reg;
        state_next = (mode_reg == MODE_FULL) ? ST_HIGH : ST_DONE;
      end
      ST_HIGH: begin
        mux_sel    = SEL_HI;
        mux_dato   = word_reg;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latches and accumulator. For a full-word load the latched word
  // is shifted down one half after the low pass, so the high pass (which
  // moves the low half of its operand to the top) delivers the upper half.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      word_reg <= '0;
      mode_reg <= '0;
      acc_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            word_reg <= req_data;
            mode_reg <= req_mode;
            acc_reg  <= '0;
            err_reg  <= (req_mode == MODE_ILL);
          end
        end
        ST_LOW: begin
          acc_reg <= acc_reg | mux_out;
          if (mode_reg == MODE_FULL) begin
            word_reg <= word_reg >> H;
          end
        end
        ST_HIGH: begin
          acc_reg <= acc_reg | mux_out;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
